div_share_arb: RTL
==================

Name: div_share_arb

Overview:
- Two-requester round-robin arbiter and sequencer that shares one 32-bit signed divider instance (div_32b port set: X, Y, in_valid, Q, R, out_valid, in_error).
- Accepts operand pairs over a valid/ready handshake and issues one in_valid pulse per operation.
- Waits for out_valid or in_error, then returns quotient, remainder and status to the owning requester.
- Has a watchdog timeout so a hung divider cannot lock out the requesters.

Parameters:
N, 32, operand/result width, matching the divider width
TIMEOUT, 64, maximum WAIT cycles before the operation is aborted with a timeout error (must be >= 2)

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  reset, asynchronous, active-high
req0_valid  input  1  requester 0 has an operand pair
req0_x  input  N  requester 0 dividend
req0_y  input  N  requester 0 divisor
req0_ready  output  1  requester 0 operands accepted this cycle
req1_valid / req1_x / req1_y / req1_ready  as above, for requester 1
resp_valid  output  1  one-cycle result pulse
resp_id  output  1  owner of resp_* (0 or 1)
resp_q  output  N  quotient
resp_r  output  N  remainder
resp_err  output  1  divider reported in_error, or a timeout occurred
resp_tmo  output  1  error cause was a timeout
div_x  output  N  to divider X
div_y  output  N  to divider Y
div_in_valid  output  1  to divider in_valid
div_q  input  N  from divider Q
div_r  input  N  from divider R
div_out_valid  input  1  from divider out_valid
div_in_error  input  1  from divider in_error
busy  output  1  high in every state except IDLE

Behaviour:
- Reset values (asynchronous, immediate on rst=1):
  - State IDLE; last_grant=1, so req0 wins first.
  - All outputs 0: op_x, op_y, owner, resp_* registers, timeout counter.
- Reset mid-operation: any state returns to IDLE at once. The pending operation is dropped with no response, and div_in_valid drops immediately.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant selection is combinational.
  - Only req0_valid high: grant 0. Only req1_valid high: grant 1.
  - Both high: grant the requester that is not last_grant.
  - reqN_ready=1 only for the granted requester, and only in IDLE. It is 0 in all other states.
  - On a valid&ready edge: latch x and y into op_x/op_y, set owner and last_grant to the grant, go to ISSUE.
- ISSUE (exactly 1 cycle): div_in_valid=1; go to WAIT; clear the timeout counter.
- div_x/div_y are driven from op_x/op_y in ISSUE, WAIT and RESP, and are 0 in IDLE.
- WAIT:
  - div_in_valid=0; the counter increments each cycle.
  - Priority at the sampling edge: div_in_error, then div_out_valid, then timeout.
  - div_in_error=1: go to RESP with err=1, tmo=0, q=r=0.
  - Else div_out_valid=1: go to RESP, capturing div_q/div_r into resp_q/resp_r, err=0.
  - Else counter reaches TIMEOUT-1: go to RESP with err=1, tmo=1, q=r=0.
- RESP (1 cycle):
  - resp_valid=1, resp_id=owner; resp_q/r/err/tmo are registered and stable for this cycle.
  - Go to IDLE.
  - resp_* fields hold their values after the pulse until the next RESP.
  - There is no response backpressure; requesters must accept the pulse.
- Latency:
  - Accept at edge k; div_in_valid high in cycle k+1.
  - resp_valid rises 1 cycle after the edge at which out_valid is sampled.
  - The next accept is possible in the cycle after RESP, giving a minimum of 4 cycles per operation plus divider latency.
- The arbiter performs no arithmetic. Signed semantics (truncating quotient, remainder takes the dividend's sign) come from the divider.
- div_out_valid or div_in_error arriving outside WAIT is ignored.
- Requests stay pending while busy. A requester holding valid is served no later than one operation after the other requester.

Test Plan:
- Single request: req0 x=100, y=7 -> one div_in_valid pulse with div_x=100, div_y=7; then resp_valid, resp_id=0, resp_q=14, resp_r=2, resp_err=0.
- Signed request: req1 x=-7 (0xFFFFFFF9), y=2 -> resp_id=1, resp_q=0xFFFFFFFD, resp_r=0xFFFFFFFF.
- Arbitration: both requesters hold valid for 4 operations from reset -> grant order 0,1,0,1; each reqN_ready pulses exactly twice; resp_id alternates to match.
- Divide by zero: req0 x=5, y=0, divider raises in_error -> resp_err=1, resp_tmo=0, resp_q=0, resp_r=0; the next request is accepted normally.
- Timeout: stub divider never asserts out_valid, TIMEOUT=64 -> resp_valid exactly 64 cycles after ISSUE, resp_err=1, resp_tmo=1; busy=0 the cycle after.
- Reset in WAIT: assert rst mid-operation -> busy, div_in_valid and resp_valid go to 0 asynchronously with no response. After release, both requesters valid -> req0 granted first.

Source files
------------

// File: rtl/div_share_arb_if.sv
// Interface for the shared-divider arbiter: two requester channels, the response
// channel and the divider port set. The arbiter takes the slave view.
interface div_share_arb_if #(
    parameter int N = 32
);
    logic         req0_valid;
    logic [N-1:0] req0_x;
    logic [N-1:0] req0_y;
    logic         req0_ready;
    logic         req1_valid;
    logic [N-1:0] req1_x;
    logic [N-1:0] req1_y;
    logic         req1_ready;

    logic         resp_valid;
    logic         resp_id;
    logic [N-1:0] resp_q;
    logic [N-1:0] resp_r;
    logic         resp_err;
    logic         resp_tmo;

    logic [N-1:0] div_x;
    logic [N-1:0] div_y;
    logic         div_in_valid;
    logic [N-1:0] div_q;
    logic [N-1:0] div_r;
    logic         div_out_valid;
    logic         div_in_error;

    logic         busy;

    modport slave (
        input  req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y,
        input  div_q, div_r, div_out_valid, div_in_error,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_q, resp_r, resp_err, resp_tmo,
        output div_x, div_y, div_in_valid, busy
    );

    modport master (
        output req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y,
        output div_q, div_r, div_out_valid, div_in_error,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_q, resp_r, resp_err, resp_tmo,
        input  div_x, div_y, div_in_valid, busy
    );
endinterface

// File: rtl/div_share_arb.sv
// Round-robin arbiter that shares one signed divider between two requesters,
// sequencing issue/wait/response with a watchdog against a hung divider.
module div_share_arb #(
    parameter int N       = 32,
    parameter int TIMEOUT = 64
) (
    input logic             clk,
    input logic             rst,
    div_share_arb_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t       state_q, state_d;
    logic         lastGrant_q, lastGrant_d;
    logic         owner_q, owner_d;
    logic [N-1:0] opX_q, opX_d;
    logic [N-1:0] opY_q, opY_d;
    logic [N-1:0] respQ_q, respQ_d;
    logic [N-1:0] respR_q, respR_d;
    logic         respErr_q, respErr_d;
    logic         respTmo_q, respTmo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         grant;
    logic         anyReq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            owner_q     <= 1'b0;
            opX_q       <= '0;
            opY_q       <= '0;
            respQ_q     <= '0;
            respR_q     <= '0;
            respErr_q   <= 1'b0;
            respTmo_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            owner_q     <= owner_d;
            opX_q       <= opX_d;
            opY_q       <= opY_d;
            respQ_q     <= respQ_d;
            respR_q     <= respR_d;
            respErr_q   <= respErr_d;
            respTmo_q   <= respTmo_d;
            cnt_q       <= cnt_d;
        end
    end

    // Under contention the requester that did not win last time gets the grant.
    always_comb begin
        anyReq = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~lastGrant_q;
        end else begin
            grant = bus.req1_valid;
        end
    end

    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        owner_d     = owner_q;
        opX_d       = opX_q;
        opY_d       = opY_q;
        respQ_d     = respQ_q;
        respR_d     = respR_q;
        respErr_d   = respErr_q;
        respTmo_d   = respTmo_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (anyReq) begin
                    opX_d       = grant ? bus.req1_x : bus.req0_x;
                    opY_d       = grant ? bus.req1_y : bus.req0_y;
                    owner_d     = grant;
                    lastGrant_d = grant;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // The watchdog fires when the incremented count reaches TIMEOUT-1,
                // so the response lands TIMEOUT cycles after the issue cycle.
                cnt_d = cnt_q + 1'b1;
                if (bus.div_in_error) begin
                    respQ_d   = '0;
                    respR_d   = '0;
                    respErr_d = 1'b1;
                    respTmo_d = 1'b0;
                    state_d   = RESP;
                end else if (bus.div_out_valid) begin
                    respQ_d   = bus.div_q;
                    respR_d   = bus.div_r;
                    respErr_d = 1'b0;
                    respTmo_d = 1'b0;
                    state_d   = RESP;
                end else if (cnt_d == CW'(TIMEOUT - 1)) begin
                    respQ_d   = '0;
                    respR_d   = '0;
                    respErr_d = 1'b1;
                    respTmo_d = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req0_ready   = (state_q == IDLE) && anyReq && !grant;
    assign bus.req1_ready   = (state_q == IDLE) && anyReq && grant;
    assign bus.div_in_valid = (state_q == ISSUE);
    assign bus.div_x        = (state_q == IDLE) ? '0 : opX_q;
    assign bus.div_y        = (state_q == IDLE) ? '0 : opY_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.resp_valid   = (state_q == RESP);
    assign bus.resp_id      = owner_q;
    assign bus.resp_q       = respQ_q;
    assign bus.resp_r       = respR_q;
    assign bus.resp_err     = respErr_q;
    assign bus.resp_tmo     = respTmo_q;
endmodule
